// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings, default frame shape and oversample ratio.
// Reused by the baud generator and the transmitter.
package uart_rx_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int DBITS_DEFAULT   = 8;
  localparam int SB_TICK_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bus: the byte, its completion strobe and status flags.
// master drives it (the receiver), slave consumes it (bus-side logic).
interface uart_rx_if
  import uart_rx_pkg::*;
#(
  parameter int DBITS = DBITS_DEFAULT
);

  logic [DBITS-1:0] data_out;
  logic             rx_done;
  logic             frame_err;
  logic             parity_err;

  modport master (
    output data_out,
    output rx_done,
    output frame_err,
    output parity_err
  );

  modport slave (
    input data_out,
    input rx_done,
    input frame_err,
    input parity_err
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs.
// RESET_VAL lets each input reset to its own inactive level.
module uart_rx_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver (8N1 by default). Define UART_RX_PARITY_EN to
// insert an even-parity bit between the data bits and the stop bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBITS   = DBITS_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic      clk_100MHz,
  input  logic      reset,
  input  logic      rx,
  input  logic      sample_tick,
  uart_rx_if.master bus
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;

  state_t           state, state_next;
  logic [SW-1:0]    s, s_next;
  logic [2:0]       n, n_next;
  logic [DBITS-1:0] b, b_next;
  logic [DBITS-1:0] data_next;
  logic             done_next;
  logic             fe_next;
  logic             rx_s;
`ifdef UART_RX_PARITY_EN
  logic             pe_pend, pe_pend_next;
  logic             pe_next;
`endif

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  uart_rx_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk_100MHz),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    data_next  = bus.data_out;
    done_next  = 1'b0;
    fe_next    = bus.frame_err;
`ifdef UART_RX_PARITY_EN
    pe_pend_next = pe_pend;
    pe_next      = bus.parity_err;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (s == SW'(7)) begin
            // Still low at mid start bit: a real frame, otherwise a glitch.
            if (!rx_s) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (s == SW'(15)) begin
            b_next = {rx_s, b[DBITS-1:1]};
            s_next = '0;
            if (n == 3'(DBITS-1)) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_tick) begin
          if (s == SW'(15)) begin
            pe_pend_next = rx_s ^ (^b);
            s_next       = '0;
            state_next   = STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (sample_tick) begin
          if (s == SW'(SB_TICK-1)) begin
            data_next  = b;
            fe_next    = ~rx_s;
            done_next  = 1'b1;
`ifdef UART_RX_PARITY_EN
            pe_next    = pe_pend;
`endif
            state_next = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state         <= IDLE;
      s             <= '0;
      n             <= '0;
      b             <= '0;
      bus.data_out  <= '0;
      bus.rx_done   <= 1'b0;
      bus.frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_pend        <= 1'b0;
      bus.parity_err <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      s             <= s_next;
      n             <= n_next;
      b             <= b_next;
      bus.data_out  <= data_next;
      bus.rx_done   <= done_next;
      bus.frame_err <= fe_next;
`ifdef UART_RX_PARITY_EN
      pe_pend        <= pe_pend_next;
      bus.parity_err <= pe_next;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames driven on rx with a 1-in-16
// sample tick; received bytes are collected by a monitor and checked per scenario.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b1;
  logic rx         = 1'b1;
  logic sample_tick;

  bit   tick_en = 1'b0;
  int   tick_cnt;
  int   tests_run = 0;
  int   fails = 0;
  int   done_count = 0;
  bit   prev_done = 1'b0;
  bit   width_err = 1'b0;
  logic [7:0] got_data[$];
  logic       got_fe[$];
  logic       got_pe[$];

  uart_rx_if #(.DBITS(8)) bus ();

  uart_rx #(.DBITS(8), .SB_TICK(16)) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .rx          (rx),
    .sample_tick (sample_tick),
    .bus         (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Sample tick every 16 clocks; the phase counter freezes while gated.
  initial begin
    sample_tick = 1'b0;
    tick_cnt    = 0;
    forever begin
      @(negedge clk_100MHz);
      if (tick_en) begin
        tick_cnt    = (tick_cnt + 1) % 16;
        sample_tick = (tick_cnt == 0);
      end else begin
        sample_tick = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_100MHz);
      if (bus.rx_done === 1'b1) begin
        done_count++;
        got_data.push_back(bus.data_out);
        got_fe.push_back(bus.frame_err);
        got_pe.push_back(bus.parity_err);
        if (prev_done) width_err = 1'b1;
      end
      prev_done = (bus.rx_done === 1'b1);
    end
  end

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      int guard = 0;
      do begin
        @(posedge clk_100MHz);
        guard++;
      end while (!sample_tick && guard < 2000);
      if (guard >= 2000) begin
        tests_run++;
        fails++;
        $display("[TB] FAIL tick_timeout: got no tick in %0d cycles, expected one within 16", guard);
        return;
      end
    end
  endtask

  task automatic send_bit(input logic v, input int k);
    @(negedge clk_100MHz);
    rx = v;
    wait_ticks(k);
  endtask

  // gap_bit selects a data bit during which ticks are gated off for 100 cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                            input logic bad_par, input int gap_bit);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_bit) begin
        send_bit(d[i], 8);
        tick_en = 1'b0;
        repeat (100) @(negedge clk_100MHz);
        tick_en = 1'b1;
        wait_ticks(8);
      end else begin
        send_bit(d[i], 16);
      end
    end
    if (PARITY_EN) send_bit((^d) ^ bad_par, 16);
    if (stop_ok) begin
      send_bit(1'b1, 16);
    end else begin
      send_bit(1'b0, 10);
      send_bit(1'b1, 22);
    end
  endtask

  task automatic clear_log();
    got_data.delete();
    got_fe.delete();
    got_pe.delete();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    rx      = 1'b1;
    tick_en = 1'b1;
    repeat (5) @(negedge clk_100MHz);
    tests_run++;
    if (bus.data_out !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h expected 00", bus.data_out); end
    tests_run++;
    if (bus.rx_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", bus.rx_done); end
    tests_run++;
    if (bus.frame_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_ferr: got %b expected 0", bus.frame_err); end
    tests_run++;
    if (bus.parity_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_perr: got %b expected 0", bus.parity_err); end
    reset = 1'b0;
    send_bit(1'b1, 40);
  endtask

  task automatic test_frame_a5();
    int c0 = done_count;
    clear_log();
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    tests_run++;
    if (done_count - c0 != 1) begin fails++; $display("[TB] FAIL a5_count: got %0d pulses expected 1", done_count - c0); end
    tests_run++;
    if (got_data[0] !== 8'hA5) begin fails++; $display("[TB] FAIL a5_data: got %h expected a5", got_data[0]); end
    tests_run++;
    if (got_fe[0] !== 1'b0) begin fails++; $display("[TB] FAIL a5_ferr: got %b expected 0", got_fe[0]); end
    tests_run++;
    if (got_pe[0] !== 1'b0) begin fails++; $display("[TB] FAIL a5_perr: got %b expected 0", got_pe[0]); end
    tests_run++;
    if (width_err !== 1'b0) begin fails++; $display("[TB] FAIL a5_width: rx_done high for more than 1 cycle, expected exactly 1"); end
    tests_run++;
    if (bus.data_out !== 8'hA5) begin fails++; $display("[TB] FAIL a5_hold: got %h expected a5", bus.data_out); end
  endtask

  task automatic test_glitch();
    int c0 = done_count;
    clear_log();
    send_bit(1'b0, 5);
    send_bit(1'b1, 20);
    tests_run++;
    if (done_count != c0) begin fails++; $display("[TB] FAIL glitch_nodone: got %0d pulses expected 0", done_count - c0); end
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    tests_run++;
    if (done_count - c0 != 1) begin fails++; $display("[TB] FAIL glitch_count: got %0d pulses expected 1", done_count - c0); end
    tests_run++;
    if (got_data[0] !== 8'h3C) begin fails++; $display("[TB] FAIL glitch_data: got %h expected 3c", got_data[0]); end
  endtask

  task automatic test_frame_error();
    int c0 = done_count;
    clear_log();
    send_frame(8'hFF, 1'b0, 1'b0, -1);
    tests_run++;
    if (done_count - c0 != 1) begin fails++; $display("[TB] FAIL ferr_count: got %0d pulses expected 1", done_count - c0); end
    tests_run++;
    if (got_data[0] !== 8'hFF) begin fails++; $display("[TB] FAIL ferr_data: got %h expected ff", got_data[0]); end
    tests_run++;
    if (got_fe[0] !== 1'b1) begin fails++; $display("[TB] FAIL ferr_flag: got %b expected 1", got_fe[0]); end
    tests_run++;
    if (bus.frame_err !== 1'b1) begin fails++; $display("[TB] FAIL ferr_hold: got %b expected 1", bus.frame_err); end
    send_frame(8'h12, 1'b1, 1'b0, -1);
    tests_run++;
    if (done_count - c0 != 2) begin fails++; $display("[TB] FAIL ferr_next_count: got %0d pulses expected 2", done_count - c0); end
    tests_run++;
    if (got_data[1] !== 8'h12) begin fails++; $display("[TB] FAIL ferr_next_data: got %h expected 12", got_data[1]); end
    tests_run++;
    if (got_fe[1] !== 1'b0) begin fails++; $display("[TB] FAIL ferr_clear: got %b expected 0", got_fe[1]); end
  endtask

  task automatic test_reset_mid_frame();
    int c0 = done_count;
    logic [7:0] d = 8'h55;
    clear_log();
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(d[i], 16);
    send_bit(d[3], 8);
    @(negedge clk_100MHz);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    tests_run++;
    if (bus.data_out !== 8'h00) begin fails++; $display("[TB] FAIL midrst_data: got %h expected 00", bus.data_out); end
    tests_run++;
    if (bus.rx_done !== 1'b0) begin fails++; $display("[TB] FAIL midrst_done: got %b expected 0", bus.rx_done); end
    tests_run++;
    if (bus.frame_err !== 1'b0) begin fails++; $display("[TB] FAIL midrst_ferr: got %b expected 0", bus.frame_err); end
    reset = 1'b0;
    send_bit(1'b1, 20);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    tests_run++;
    if (done_count - c0 != 1) begin fails++; $display("[TB] FAIL midrst_count: got %0d pulses expected 1", done_count - c0); end
    tests_run++;
    if (got_data[0] !== 8'h81) begin fails++; $display("[TB] FAIL midrst_rxdata: got %h expected 81", got_data[0]); end
  endtask

  task automatic test_back_to_back();
    int c0 = done_count;
    logic [7:0] exp_d[3] = '{8'h00, 8'hFF, 8'h7E};
    clear_log();
    send_frame(exp_d[0], 1'b1, 1'b0, -1);
    send_frame(exp_d[1], 1'b1, 1'b0, -1);
    send_frame(exp_d[2], 1'b1, 1'b0, 3);
    tests_run++;
    if (done_count - c0 != 3) begin fails++; $display("[TB] FAIL b2b_count: got %0d pulses expected 3", done_count - c0); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (got_data[i] !== exp_d[i]) begin fails++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, got_data[i], exp_d[i]); end
      tests_run++;
      if (got_fe[i] !== 1'b0) begin fails++; $display("[TB] FAIL b2b_ferr%0d: got %b expected 0", i, got_fe[i]); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int c0 = done_count;
    clear_log();
    send_frame(8'h07, 1'b1, 1'b0, -1);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    tests_run++;
    if (done_count - c0 != 2) begin fails++; $display("[TB] FAIL par_count: got %0d pulses expected 2", done_count - c0); end
    tests_run++;
    if (got_pe[0] !== 1'b0) begin fails++; $display("[TB] FAIL par_good: got %b expected 0", got_pe[0]); end
    tests_run++;
    if (got_pe[1] !== 1'b1) begin fails++; $display("[TB] FAIL par_bad: got %b expected 1", got_pe[1]); end
    tests_run++;
    if (got_fe[1] !== 1'b0) begin fails++; $display("[TB] FAIL par_ferr: got %b expected 0", got_fe[1]); end
    tests_run++;
    if (got_data[1] !== 8'h07) begin fails++; $display("[TB] FAIL par_data: got %h expected 07", got_data[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    tests_run++;
    if (width_err !== 1'b0) begin fails++; $display("[TB] FAIL done_width: rx_done pulse wider than 1 cycle, expected 1"); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
